pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Holds the architectural program counter and runs one instruction fetch at a time from instruction memory over a request/grant/response handshake. It presents the fetched instruction and its PC to decode, and consumes the next-PC value produced downstream by the next-PC logic. It commits that value into the PC when decode accepts the instruction. It sits between instruction memory and decode, closing the PC → fetch → decode → next-PC → PC loop of the CPU.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset; must be word-aligned.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- npc_i  in  32  next PC from next-PC logic; sampled only on accept.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc_o.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- inst_o  out  32  buffered instruction.
- inst_valid_o  out  1  inst_o/pc_o valid for decode.
- id_ready_i  in  1  decode accepts instruction this cycle.
- pc_o  out  32  current PC, fed to next-PC logic and decode.
- inst_cnt_o  out  32  count of accepted instructions.
- fault_o  out  1  misaligned next PC detected; sticky.

## Operation
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- Reset (async): state=IDLE, pc_o=RESET_PC, inst_o=0, inst_valid_o=0, inst_cnt_o=0, fault_o=0, imem_req=0.
- IDLE → REQ unconditionally on the first clock edge after rst deasserts.
- REQ: imem_req=1. If imem_gnt=1, go to WAIT. Otherwise stay, with imem_addr held stable.
- WAIT: imem_req=0. If imem_rvalid=1, inst_o<=imem_rdata, inst_valid_o<=1, and go to HOLD. Otherwise stay; there is no timeout.
- HOLD: inst_valid_o=1. Accept = inst_valid_o & id_ready_i.
- On accept with npc_i[1:0]==2'b00:
  - pc_o<=npc_i, inst_cnt_o<=inst_cnt_o+1 (mod 2^32, wraps silently), inst_valid_o<=0.
  - Go to REQ.
- On accept with npc_i[1:0]!=2'b00:
  - pc_o holds; inst_cnt_o still increments (the instruction retired); inst_valid_o<=0, fault_o<=1.
  - Go to FAULT.
- FAULT: imem_req=0, inst_valid_o=0, all registers hold. Only rst exits this state.
- imem_rvalid outside WAIT is ignored: no capture, no state change.
- imem_gnt outside REQ is ignored.
- inst_o and pc_o are stable throughout HOLD regardless of memory inputs.
- Only one fetch is outstanding at any time.
- Reset mid-fetch (REQ/WAIT/HOLD) abandons the transaction. Instruction memory must tolerate an ungranted request being dropped. A response arriving after reset is discarded per the rule above.

## Timing
- imem_req and inst_valid_o are Moore outputs decoded from state; no input → output combinational path.
- imem_addr is driven directly from the pc_o register.
- Minimum fetch-to-accept: 3 cycles:
  - REQ with gnt in cycle 0.
  - WAIT with rvalid in cycle 1.
  - HOLD with id_ready in cycle 2.
- Next request is asserted in cycle 3, so peak throughput is one instruction per 3 cycles.
- After rst deasserts, the first imem_req rises one cycle later (IDLE → REQ).
- Each cycle of gnt delay or rvalid delay adds 1 cycle. Each cycle id_ready_i is low in HOLD adds 1 cycle.
- npc_i is registered only on the accept edge; its value in other cycles has no effect.

## Test plan
- Reset/first fetch: assert rst, release; check pc_o=32'h3000, imem_req=0 during reset, imem_req=1 one cycle after release, imem_addr=32'h3000.
- Zero-wait stream: gnt=1 immediately, rvalid one cycle later with rdata=32'h2008_0005, id_ready=1, npc_i=pc_o+4 → inst_o=32'h2008_0005 in HOLD, pc_o steps 3000→3004→3008 every 3 cycles, inst_cnt_o=2 after two accepts.
- Backpressure: gnt delayed 2 cycles, rvalid delayed 3, id_ready low 4 cycles in HOLD → imem_addr/inst_o/pc_o stable throughout, period 12 cycles, exactly one accept.
- Jump/branch: on accept drive npc_i=32'h0040_0010 → next imem_addr=32'h0040_0010; stray rvalid pulse during REQ ignored, inst_o unchanged.
- Misaligned next PC: accept with npc_i=32'h0000_3006 → fault_o=1, pc_o stays at old value, imem_req stays 0, inst_cnt_o incremented by 1; rst clears fault_o.
- Reset mid-WAIT and counter wrap: preload so inst_cnt_o=32'hFFFF_FFFF, accept → 0. Assert rst in WAIT and send rvalid after release → response ignored, state REQ, pc_o=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch unit.
// Fetches from imem over req/gnt/rvalid and commits next-PC when decode accepts.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_3000,
  parameter logic [31:0] INST_CNT_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_cnt_o,
  output logic        fault_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] cnt_q;
  logic        fault_q;

  // inst_valid_o is decoded from HOLD rather than kept as a separate flop;
  // it is set on capture and cleared on accept exactly as HOLD is entered/left.
  always_comb begin
    imem_req     = (state == REQ);
    inst_valid_o = (state == HOLD);
  end

  assign imem_addr  = pc_q;
  assign pc_o       = pc_q;
  assign inst_o     = inst_q;
  assign inst_cnt_o = cnt_q;
  assign fault_o    = fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= INST_CNT_INIT;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_gnt) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            inst_q <= imem_rdata;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (id_ready_i) begin
            cnt_q <= cnt_q + 32'd1;
            // A misaligned target still retires the current instruction.
            if (npc_i[1:0] == 2'b00) begin
              pc_q  <= npc_i;
              state <= REQ;
            end else begin
              fault_q <= 1'b1;
              state   <= FAULT;
            end
          end
        end
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a fetch scoreboard and immediate assertions.
// A second instance preloaded near counter wrap runs on the same stimulus.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        id_ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_cnt_o;
  logic        fault_o;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_inst;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_cnt;
  logic        w_fault;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model_pc;
  logic [31:0] model_cnt;
  logic [31:0] model_wcnt;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .npc_i(npc_i),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .id_ready_i(id_ready_i),
    .pc_o(pc_o), .inst_cnt_o(inst_cnt_o), .fault_o(fault_o)
  );

  pc_fetch_unit #(.RESET_PC(32'h0000_3000), .INST_CNT_INIT(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst(rst), .npc_i(npc_i),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_o(w_inst), .inst_valid_o(w_valid), .id_ready_i(id_ready_i),
    .pc_o(w_pc), .inst_cnt_o(w_cnt), .fault_o(w_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left in REQ (or FAULT on a misaligned target).
  task automatic fetch(input int unsigned g, input int unsigned r, input int unsigned d,
                       input logic [31:0] data, input logic [31:0] npc);
    exp_t e;
    for (int unsigned i = 0; i < g; i++) begin
      chk("req_pending", {31'd0, imem_req}, 32'd1);
      chk("addr_stable_req", imem_addr, model_pc);
      imem_rvalid = 1'b1;
      imem_rdata  = ~data;
      tick();
      imem_rvalid = 1'b0;
    end
    chk("req_high", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, model_pc);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("wait_req_low", {31'd0, imem_req}, 32'd0);
    for (int unsigned i = 0; i < r; i++) begin
      tick();
      chk("wait_no_valid", {31'd0, inst_valid_o}, 32'd0);
      chk("addr_stable_wait", imem_addr, model_pc);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    e.pc   = model_pc;
    e.inst = data;
    sb.push_back(e);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("hold_valid", {31'd0, inst_valid_o}, 32'd1);
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL sb_empty observed=0 expected=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_inst", inst_o, e.inst);
      chk("sb_pc", pc_o, e.pc);
    end
    for (int unsigned i = 0; i < d; i++) begin
      imem_rvalid = 1'b1;
      imem_gnt    = 1'b1;
      imem_rdata  = ~data;
      npc_i       = $urandom;
      tick();
      chk("hold_inst_stable", inst_o, e.inst);
      chk("hold_pc_stable", pc_o, e.pc);
      chk("hold_addr_stable", imem_addr, e.pc);
      chk("hold_valid_stable", {31'd0, inst_valid_o}, 32'd1);
      chk("hold_req_low", {31'd0, imem_req}, 32'd0);
    end
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    id_ready_i  = 1'b1;
    npc_i       = npc;
    tick();
    id_ready_i  = 1'b0;
    npc_i       = 32'hDEAD_BEE3;
    model_cnt++;
    model_wcnt++;
    chk("inst_cnt", inst_cnt_o, model_cnt);
    chk("inst_cnt_wrap", w_cnt, model_wcnt);
    chk("valid_cleared", {31'd0, inst_valid_o}, 32'd0);
    if (npc[1:0] == 2'b00) begin
      model_pc = npc;
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", imem_addr, npc);
      chk("no_fault", {31'd0, fault_o}, 32'd0);
    end else begin
      chk("fault_set", {31'd0, fault_o}, 32'd1);
      chk("fault_pc_hold", pc_o, model_pc);
      chk("fault_req_low", {31'd0, imem_req}, 32'd0);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    model_pc   = 32'h0000_3000;
    model_cnt  = 32'h0;
    model_wcnt = 32'hFFFF_FFFF;
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    npc_i       = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    id_ready_i  = 1'b0;

    // Reset and first request
    apply_reset();
    chk("rst_pc", pc_o, 32'h0000_3000);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_cnt", inst_cnt_o, 32'd0);
    chk("rst_fault", {31'd0, fault_o}, 32'd0);
    chk("rst_wrap_cnt", w_cnt, 32'hFFFF_FFFF);
    rst = 1'b0;
    chk("idle_req_low", {31'd0, imem_req}, 32'd0);
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_3000);

    // Zero-wait stream
    fetch(0, 0, 0, 32'h2008_0005, 32'h0000_3004);
    fetch(0, 0, 0, 32'h2008_0005, 32'h0000_3008);
    chk("stream_cnt", inst_cnt_o, 32'd2);
    chk("stream_pc", pc_o, 32'h0000_3008);

    // Backpressure on every handshake
    fetch(2, 3, 4, 32'h1234_5678, 32'h0000_300C);
    chk("bp_cnt", inst_cnt_o, 32'd3);

    // Jump, then a stray response while requesting
    fetch(0, 0, 0, 32'hA5A5_0001, 32'h0040_0010);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFFFF_0000;
    tick();
    imem_rvalid = 1'b0;
    chk("stray_inst", inst_o, 32'hA5A5_0001);
    chk("stray_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("stray_req", {31'd0, imem_req}, 32'd1);
    fetch(1, 1, 1, 32'h0BAD_F00D, 32'h0040_0014);

    // Reset mid-WAIT; the late response must be dropped
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("midwait_req", {31'd0, imem_req}, 32'd0);
    apply_reset();
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0000;
    tick();
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_pc", pc_o, 32'h0000_3000);
    chk("post_rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("post_rst_inst", inst_o, 32'd0);
    tick();
    imem_rvalid = 1'b0;
    chk("post_rst_still_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_cnt", inst_cnt_o, 32'd0);

    // Misaligned target: fault sticks until reset
    fetch(0, 0, 0, 32'h1111_2222, 32'h0000_3006);
    chk("fault_cnt", inst_cnt_o, 32'd1);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    id_ready_i  = 1'b1;
    npc_i       = 32'h0000_4000;
    tick();
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    id_ready_i  = 1'b0;
    chk("fault_sticky", {31'd0, fault_o}, 32'd1);
    chk("fault_pc_frozen", pc_o, 32'h0000_3000);
    chk("fault_req_frozen", {31'd0, imem_req}, 32'd0);
    chk("fault_valid_low", {31'd0, inst_valid_o}, 32'd0);
    chk("fault_cnt_frozen", inst_cnt_o, 32'd1);
    chk("fault_inst_frozen", inst_o, 32'h1111_2222);
    apply_reset();
    chk("rst_clears_fault", {31'd0, fault_o}, 32'd0);
    rst = 1'b0;
    tick();
    chk("refetch_req", {31'd0, imem_req}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
